// File: rtl/rast_sample_sequencer.sv
// Snaps a bounding box to the sub-sample grid and walks it row-major, one sample per handshake.
// The first sample appears the cycle after accept, and all sample outputs hold while samp_ready_i is low.
module rast_sample_sequencer #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int TAGW   = 8,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              box_valid_i,
  output logic              box_ready_o,
  input  logic [SIGFIG-1:0] box_ll_x_i,
  input  logic [SIGFIG-1:0] box_ll_y_i,
  input  logic [SIGFIG-1:0] box_ur_x_i,
  input  logic [SIGFIG-1:0] box_ur_y_i,
  input  logic [1:0]        ss_log2_i,
  input  logic [TAGW-1:0]   box_tag_i,
  output logic              samp_valid_o,
  input  logic              samp_ready_i,
  output logic [SIGFIG-1:0] samp_x_o,
  output logic [SIGFIG-1:0] samp_y_o,
  output logic [TAGW-1:0]   samp_tag_o,
  output logic              samp_last_o,
  output logic              box_done_o,
  output logic [CNTW-1:0]   samp_count_o
);

  // One guard bit keeps aligned corners and x+step from wrapping.
  localparam int W = SIGFIG + 1;
  localparam logic signed [W-1:0] ONE = W'(1);

  typedef enum logic {IDLE, WALK} state_t;

  typedef struct packed {
    logic signed [W-1:0] llx;
    logic signed [W-1:0] urx;
    logic signed [W-1:0] ury;
  } box_t;

  state_t state_q, state_d;
  box_t   box_q, box_al;

  logic signed [W-1:0] step_q, step_in, mask_in;
  logic signed [W-1:0] ll_x_w, ll_y_w, ur_x_w, ur_y_w, lly_al;
  logic signed [W-1:0] x_q, y_q, x_nxt, y_nxt;
  logic [TAGW-1:0]     tag_q;
  logic [CNTW-1:0]     cnt_q;
  logic                done_q;
  logic                box_empty, x_fits, y_fits;
  logic                accept, handshake;

  assign ll_x_w = {box_ll_x_i[SIGFIG-1], box_ll_x_i};
  assign ll_y_w = {box_ll_y_i[SIGFIG-1], box_ll_y_i};
  assign ur_x_w = {box_ur_x_i[SIGFIG-1], box_ur_x_i};
  assign ur_y_w = {box_ur_y_i[SIGFIG-1], box_ur_y_i};

  assign step_in = ONE << (RADIX - int'(ss_log2_i));
  assign mask_in = ~(step_in - ONE);

  // Lower-left rounds up onto the grid, upper-right rounds down.
  assign box_al.llx = (ll_x_w + step_in - ONE) & mask_in;
  assign lly_al     = (ll_y_w + step_in - ONE) & mask_in;
  assign box_al.urx = ur_x_w & mask_in;
  assign box_al.ury = ur_y_w & mask_in;
  assign box_empty  = (box_al.llx > box_al.urx) || (lly_al > box_al.ury);

  assign x_nxt  = x_q + step_q;
  assign y_nxt  = y_q + step_q;
  assign x_fits = (x_nxt <= box_q.urx);
  assign y_fits = (y_nxt <= box_q.ury);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    box_ready_o  = 1'b0;
    samp_valid_o = 1'b0;
    samp_last_o  = 1'b0;
    accept       = 1'b0;
    handshake    = 1'b0;
    case (state_q)
      IDLE: begin
        box_ready_o = 1'b1;
        if (box_valid_i) begin
          accept = 1'b1;
          if (!box_empty) state_d = WALK;
        end
      end
      WALK: begin
        samp_valid_o = 1'b1;
        samp_last_o  = !x_fits && !y_fits;
        handshake    = samp_ready_i;
        if (samp_ready_i && !x_fits && !y_fits) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_q  <= '0;
      step_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      tag_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        box_q  <= box_al;
        step_q <= step_in;
        tag_q  <= box_tag_i;
        cnt_q  <= '0;
        if (box_empty) begin
          done_q <= 1'b1;
        end else begin
          x_q <= box_al.llx;
          y_q <= lly_al;
        end
      end
      if (handshake) begin
        if (!(&cnt_q)) cnt_q <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        if (x_fits) begin
          x_q <= x_nxt;
        end else if (y_fits) begin
          x_q <= box_q.llx;
          y_q <= y_nxt;
        end else begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign samp_x_o     = x_q[SIGFIG-1:0];
  assign samp_y_o     = y_q[SIGFIG-1:0];
  assign samp_tag_o   = tag_q;
  assign samp_count_o = cnt_q;
  assign box_done_o   = done_q;

endmodule

// File: tb/tb_rast_sample_sequencer.sv
// Directed and randomized boxes checked against a grid-enumeration reference model.
module tb_rast_sample_sequencer;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int TAGW   = 8;
  localparam int CNTW   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              box_valid_i;
  logic              box_ready_o;
  logic [SIGFIG-1:0] box_ll_x_i, box_ll_y_i, box_ur_x_i, box_ur_y_i;
  logic [1:0]        ss_log2_i;
  logic [TAGW-1:0]   box_tag_i;
  logic              samp_valid_o;
  logic              samp_ready_i;
  logic [SIGFIG-1:0] samp_x_o, samp_y_o;
  logic [TAGW-1:0]   samp_tag_o;
  logic              samp_last_o;
  logic              box_done_o;
  logic [CNTW-1:0]   samp_count_o;

  int checks = 0;
  int errors = 0;

  rast_sample_sequencer #(.SIGFIG(SIGFIG), .RADIX(RADIX), .TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .box_valid_i(box_valid_i), .box_ready_o(box_ready_o),
    .box_ll_x_i(box_ll_x_i), .box_ll_y_i(box_ll_y_i),
    .box_ur_x_i(box_ur_x_i), .box_ur_y_i(box_ur_y_i),
    .ss_log2_i(ss_log2_i), .box_tag_i(box_tag_i),
    .samp_valid_o(samp_valid_o), .samp_ready_i(samp_ready_i),
    .samp_x_o(samp_x_o), .samp_y_o(samp_y_o), .samp_tag_o(samp_tag_o),
    .samp_last_o(samp_last_o), .box_done_o(box_done_o), .samp_count_o(samp_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, box_ready_o, 1);
    chk({tag, "_valid"}, samp_valid_o, 0);
    chk({tag, "_last"},  samp_last_o, 0);
    chk({tag, "_done"},  box_done_o, 0);
    chk({tag, "_x"},     samp_x_o, 0);
    chk({tag, "_y"},     samp_y_o, 0);
    chk({tag, "_tag"},   samp_tag_o, 0);
    chk({tag, "_count"}, samp_count_o, 0);
  endtask

  // Drives one box and follows it to retirement; abort_after >= 0 leaves
  // the walk after that many handshakes so the caller can reset mid-box.
  task automatic run_box(input longint llx, input longint lly, input longint urx, input longint ury,
                         input int ss, input logic [TAGW-1:0] tag, input int stall_idx,
                         input bit rnd_ready, input int abort_after);
    longint step, ax0, ay0, ax1, ay1;
    longint ex[$];
    longint ey[$];
    int n, idx, stalled, cyc;
    bit rdy;
    step = longint'(1) << (RADIX - ss);
    ax0 = -fdiv(-llx, step) * step;
    ay0 = -fdiv(-lly, step) * step;
    ax1 = fdiv(urx, step) * step;
    ay1 = fdiv(ury, step) * step;
    for (longint yy = ay0; yy <= ay1; yy += step)
      for (longint xx = ax0; xx <= ax1; xx += step) begin
        ex.push_back(xx);
        ey.push_back(yy);
      end
    n = ex.size();

    @(negedge clk);
    chk("box_ready_idle", box_ready_o, 1);
    box_ll_x_i = llx[SIGFIG-1:0];
    box_ll_y_i = lly[SIGFIG-1:0];
    box_ur_x_i = urx[SIGFIG-1:0];
    box_ur_y_i = ury[SIGFIG-1:0];
    ss_log2_i  = 2'(ss);
    box_tag_i  = tag;
    box_valid_i = 1'b1;
    @(negedge clk);
    box_valid_i = 1'b0;
    ss_log2_i = 2'($urandom_range(0, 3));
    box_tag_i = 8'($urandom);

    if (n == 0) begin
      chk("empty_valid", samp_valid_o, 0);
      chk("empty_done", box_done_o, 1);
      chk("empty_count", samp_count_o, 0);
      chk("empty_ready", box_ready_o, 1);
      @(negedge clk);
      chk("empty_done_once", box_done_o, 0);
      chk("empty_valid_after", samp_valid_o, 0);
      return;
    end

    idx = 0; stalled = 0; cyc = 0;
    while (idx < n && cyc < 4 * n + 20) begin
      chk("samp_valid", samp_valid_o, 1);
      chk("samp_x", $signed(samp_x_o), ex[idx]);
      chk("samp_y", $signed(samp_y_o), ey[idx]);
      chk("samp_tag", samp_tag_o, tag);
      chk("samp_last", samp_last_o, (idx == n - 1));
      chk("samp_count", samp_count_o, idx);
      chk("walk_done_low", box_done_o, 0);
      chk("walk_ready_low", box_ready_o, 0);
      if (abort_after >= 0 && idx == abort_after) begin
        samp_ready_i = 1'b0;
        return;
      end
      if (idx == stall_idx && stalled < 3) begin
        rdy = 1'b0;
        stalled++;
      end else if (rnd_ready) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      samp_ready_i = rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    samp_ready_i = 1'b0;
    chk("walk_complete", idx, n);
    chk("end_valid", samp_valid_o, 0);
    chk("end_done", box_done_o, 1);
    chk("end_count", samp_count_o, n);
    chk("end_ready", box_ready_o, 1);
    chk("end_last", samp_last_o, 0);
    @(negedge clk);
    chk("end_done_once", box_done_o, 0);
    chk("end_count_hold", samp_count_o, n);
  endtask

  initial begin
    longint rx, ry;
    rst = 1'b1;
    box_valid_i = 1'b0;
    samp_ready_i = 1'b0;
    box_ll_x_i = '0; box_ll_y_i = '0; box_ur_x_i = '0; box_ur_y_i = '0;
    ss_log2_i = '0;
    box_tag_i = '0;
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    run_box(0, 0, 2048, 1024, 0, 8'h11, -1, 1'b0, -1);
    run_box(0, 0, 2048, 1024, 0, 8'h22, 2, 1'b0, -1);
    run_box(100, 100, 1000, 600, 1, 8'h33, -1, 1'b0, -1);
    run_box(2048, 0, 1024, 1024, 0, 8'h44, -1, 1'b0, -1);
    run_box(-1024, -1024, 0, 0, 0, 8'h55, -1, 1'b0, -1);

    run_box(0, 0, 2048, 1024, 0, 8'h66, -1, 1'b0, 2);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    chk_reset_vals("reset_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_done", box_done_o, 0);
      chk("post_reset_valid", samp_valid_o, 0);
    end
    run_box(3072, 512, 5120, 1536, 0, 8'h77, -1, 1'b0, -1);

    for (int b = 0; b < 12; b++) begin
      rx = longint'($urandom_range(0, 10000)) - 5000;
      ry = longint'($urandom_range(0, 10000)) - 5000;
      run_box(rx, ry,
              rx + longint'($urandom_range(0, 2500)) - 300,
              ry + longint'($urandom_range(0, 2500)) - 300,
              int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 6)), 1'b1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
